// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard and sequencing control for the 5-stage pipeline.
// It produces the stall/flush controls for the F/D, D/E, E/M and M/W buffers.
// It produces the E-stage forwarding selects.
// A RUN/MEM_WAIT/ABORT FSM freezes the pipeline while data memory is busy.
// Optional macro HAZARD_PERF_EN adds stall/flush performance counters.
// When the macro is undefined, stall_cnt and flush_cnt are tied to zero.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic [REG_W-1:0] rs1E,
  input  logic [REG_W-1:0] rs2E,
  input  logic [REG_W-1:0] rdE,
  input  logic [REG_W-1:0] rdM,
  input  logic [REG_W-1:0] rdW,
  input  logic             rf_enE,
  input  logic             rf_enM,
  input  logic             rf_enW,
  input  logic             mem_readE,
  input  logic             jump_enE,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forward_AE,
  output logic [1:0]       forward_BE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ABORT    = 2'd2
  } state_t;

  localparam int                WCNT_W = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WCNT_W-1:0] TMO    = WCNT_W'(MEM_TIMEOUT);

  state_t            r_state, w_state_nxt;
  logic [WCNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

  logic       w_lu, w_mstall;
  logic       w_sF, w_sD, w_sE, w_sM, w_fD, w_fE, w_fW, w_err;
  logic [1:0] w_fwd_a, w_fwd_b;

  // rf_enE is part of the stage interface, but load-use only needs mem_readE.
  logic w_unused;
  assign w_unused = rf_enE;

  assign w_lu      = mem_readE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
  assign w_mstall  = dmem_req && !dmem_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  // Forwarding selects, evaluated in every state; M has priority over W.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (rf_enM && (rdM != '0) && (rdM == rs1E))      w_fwd_a = 2'b10;
    else if (rf_enW && (rdW != '0) && (rdW == rs1E)) w_fwd_a = 2'b01;
    if (rf_enM && (rdM != '0) && (rdM == rs2E))      w_fwd_b = 2'b10;
    else if (rf_enW && (rdW != '0) && (rdW == rs2E)) w_fwd_b = 2'b01;
  end

  // FSM next-state and raw stall/flush decode (before reset gating).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sF = 1'b0; w_sD = 1'b0; w_sE = 1'b0; w_sM = 1'b0;
    w_fD = 1'b0; w_fE = 1'b0; w_fW = 1'b0; w_err = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_mstall) begin
          // A memory freeze hides redirect/load-use; a held jump re-presents later.
          w_sF = 1'b1; w_sD = 1'b1; w_sE = 1'b1; w_sM = 1'b1; w_fW = 1'b1;
          w_state_nxt = S_MEM_WAIT;
          w_cnt_nxt   = WCNT_W'(1);
        end else if (jump_enE) begin
          // A redirect squashes the load-use stall; the younger ops are flushed anyway.
          w_fD = 1'b1; w_fE = 1'b1;
        end else if (w_lu) begin
          w_sF = 1'b1; w_sD = 1'b1; w_fE = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_sF = 1'b1; w_sD = 1'b1; w_sE = 1'b1; w_sM = 1'b1; w_fW = 1'b1;
          // The count includes the RUN cycle that began the wait.
          // Give up once MEM_TIMEOUT stalled cycles have elapsed.
          if (w_cnt_inc >= TMO) begin
            w_state_nxt = S_ABORT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_ABORT: begin
        w_err = 1'b1;
        w_fD = 1'b1; w_fE = 1'b1; w_fW = 1'b1;
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // While in reset, the stage buffers are fed bubbles and never held.
  assign stallF     = rst & w_sF;
  assign stallD     = rst & w_sD;
  assign stallE     = rst & w_sE;
  assign stallM     = rst & w_sM;
  assign flushD     = ~rst | w_fD;
  assign flushE     = ~rst | w_fE;
  assign flushW     = ~rst | w_fW;
  assign forward_AE = rst ? w_fwd_a : 2'b00;
  assign forward_BE = rst ? w_fwd_b : 2'b00;
  assign mem_err    = rst & w_err;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  // Free-running perf counters; they wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stallF) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flushE) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with directed vectors.
// The stimulus thread pushes the hand-computed outputs for each vector.
// A negedge monitor pops each entry and compares it against the DUT.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  logic clk, rst;
  logic [REG_W-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic rf_enE, rf_enM, rf_enW, mem_readE, jump_enE, dmem_req, dmem_ready;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err;
  logic [1:0] forward_AE, forward_BE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic sF, sD, sE, sM, fD, fE, fW;
    logic [1:0] fa, fb;
    logic err;
  } out_t;

  out_t             q_exp[$];
  string            q_name[$];
  logic [CNT_W-1:0] q_sc[$];
  logic [CNT_W-1:0] q_fc[$];
  int n_chk  = 0;
  int n_fail = 0;
  logic [CNT_W-1:0] m_sc = '0;
  logic [CNT_W-1:0] m_fc = '0;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .rf_enE(rf_enE), .rf_enM(rf_enM), .rf_enW(rf_enW), .mem_readE(mem_readE),
    .jump_enE(jump_enE), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forward_AE(forward_AE), .forward_BE(forward_BE), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(input logic sF, sD, sE, sM, fD, fE, fW,
                              input logic [1:0] fa, fb, input logic err);
    mk = '{sF, sD, sE, sM, fD, fE, fW, fa, fb, err};
  endfunction

  out_t Z, RST, LU, JMP, MST, ABT;

  // Push the expected outputs for the inputs now applied, then advance one cycle.
  task automatic chk(input string nm, input out_t e);
    if (!rst) begin m_sc = '0; m_fc = '0; end
    q_exp.push_back(e);
    q_name.push_back(nm);
    q_sc.push_back(m_sc);
    q_fc.push_back(m_fc);
`ifdef HAZARD_PERF_EN
    if (rst) begin
      if (e.sF) m_sc = m_sc + 1'b1;
      if (e.fE) m_fc = m_fc + 1'b1;
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic clr();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
    rf_enE = 0; rf_enM = 0; rf_enW = 0; mem_readE = 0; jump_enE = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  // Monitor: compare every presented output sample against the scoreboard.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      out_t e, a;
      string nm;
      logic [CNT_W-1:0] esc, efc;
      e = q_exp.pop_front(); nm = q_name.pop_front();
      esc = q_sc.pop_front(); efc = q_fc.pop_front();
      a = '{stallF, stallD, stallE, stallM, flushD, flushE, flushW,
            forward_AE, forward_BE, mem_err};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got sF,sD,sE,sM,fD,fE,fW,fa,fb,err=%b expected %b", nm, a, e);
      end
      n_chk++;
      if (stall_cnt !== esc || flush_cnt !== efc) begin
        n_fail++;
        $display("FAIL %s_cnt: got stall_cnt=%0d flush_cnt=%0d expected %0d %0d",
                 nm, stall_cnt, flush_cnt, esc, efc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Z   = mk(0,0,0,0,0,0,0,2'b00,2'b00,0);
    RST = mk(0,0,0,0,1,1,1,2'b00,2'b00,0);
    LU  = mk(1,1,0,0,0,1,0,2'b00,2'b00,0);
    JMP = mk(0,0,0,0,1,1,0,2'b00,2'b00,0);
    MST = mk(1,1,1,1,0,0,1,2'b00,2'b00,0);
    ABT = mk(0,0,0,0,1,1,1,2'b00,2'b00,1);
    clr();
    rst = 1'b0;
    @(posedge clk); #1;
    // Reset must gate forwarding and memory stalls.
    rf_enM = 1; rdM = 7; rs1E = 7; dmem_req = 1;
    chk("rst_gated", RST);
    clr(); rst = 1'b1;
    chk("idle", Z);

    // Load-use: one bubble, then quiet.
    mem_readE = 1; rdE = 5; rs1D = 5;
    chk("lu_rs1", LU);
    clr();
    chk("lu_after", Z);
    mem_readE = 1; rdE = 6; rs2D = 6;
    chk("lu_rs2", LU);
    clr(); mem_readE = 1; rdE = 0; rs1D = 0;
    chk("lu_x0", Z);
    clr(); rdE = 5; rs1D = 5;
    chk("lu_noload", Z);

    // Forwarding priority and x0 exclusion.
    clr(); rf_enM = 1; rf_enW = 1; rdM = 7; rdW = 7; rs1E = 7; rs2E = 0;
    chk("fwd_m", mk(0,0,0,0,0,0,0,2'b10,2'b00,0));
    rdM = 0;
    chk("fwd_w_rdm0", mk(0,0,0,0,0,0,0,2'b01,2'b00,0));
    rdM = 7; rf_enM = 0; rs2E = 7;
    chk("fwd_w_enm0", mk(0,0,0,0,0,0,0,2'b01,2'b01,0));
    rf_enM = 1; rdW = 3; rs1E = 3;
    chk("fwd_mix", mk(0,0,0,0,0,0,0,2'b01,2'b10,0));
    rf_enM = 0; rf_enW = 0;
    chk("fwd_none", Z);

    // Redirect overrides load-use.
    clr(); jump_enE = 1; mem_readE = 1; rdE = 5; rs1D = 5;
    chk("jmp_lu", JMP);
    clr(); jump_enE = 1;
    chk("jmp", JMP);

    // Ready in the same cycle as the request: no freeze.
    clr(); dmem_req = 1; dmem_ready = 1;
    chk("mem_fast", Z);

    // Three waiting cycles, then ready; a jump and forwarding ride along.
    dmem_ready = 0; jump_enE = 1; mem_readE = 1; rdE = 5; rs1D = 5;
    chk("mw_run", MST);
    rf_enM = 1; rdM = 9; rs1E = 9;
    chk("mw_1", mk(1,1,1,1,0,0,1,2'b10,2'b00,0));
    rf_enM = 0;
    chk("mw_2", MST);
    dmem_ready = 1;
    chk("mw_ready", Z);
    dmem_req = 0; dmem_ready = 0; mem_readE = 0;
    chk("mw_jmp_again", JMP);

    // Timeout at MEM_TIMEOUT=4: four stall cycles, one abort, back to RUN.
    clr(); dmem_req = 1;
    chk("to_1", MST);
    chk("to_2", MST);
    chk("to_3", MST);
    chk("to_4", MST);
    chk("to_abort", ABT);
    dmem_req = 0;
    chk("to_run", Z);

    // Asynchronous reset in the middle of a wait.
    dmem_req = 1;
    chk("ar_run", MST);
    chk("ar_wait", MST);
    rst = 1'b0;
    chk("ar_rst", RST);
    chk("ar_rst_hold", RST);
    dmem_req = 0; rst = 1'b1;
    chk("ar_release", Z);
    mem_readE = 1; rdE = 4; rs2D = 4;
    chk("ar_lu", LU);
    clr();
    chk("end_idle", Z);

    @(negedge clk); @(negedge clk);
    n_chk++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Drives stall/flush of the F/D, D/E, E/M and M/W pipeline buffers.
- Generates the E-stage operand-forwarding selects.
- Runs a small FSM that freezes the pipeline while data memory is not ready.
- Sits beside the decode/execute control buffers; its outputs gate every stage register.

Parameters:
REG_W, 5, register index width.
MEM_TIMEOUT, 16, max wait cycles for dmem_ready before an error abort (≥1).
CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset.
rs1D, rs2D  in  REG_W  source regs of the instruction in D.
rs1E, rs2E, rdE  in  REG_W  source/dest regs of the instruction in E.
rdM, rdW  in  REG_W  dest regs in M and W.
rf_enE, rf_enM, rf_enW  in  1  regfile write enables per stage.
mem_readE  in  1  instruction in E is a load.
jump_enE  in  1  taken branch/jump resolved in E.
dmem_req  in  1  M-stage instruction accesses data memory.
dmem_ready  in  1  data memory completes the access this cycle.
stallF, stallD, stallE, stallM  out  1  hold the corresponding stage register.
flushD, flushE, flushW  out  1  load a bubble (all control bits 0) into the D, E or W register.
forward_AE, forward_BE  out  2  00 regfile, 10 from M, 01 from W.
mem_err  out  1  one-cycle pulse on memory timeout.
stall_cnt, flush_cnt  out  CNT_W  perf counters (see Optional Feature).

Behaviour:
- FSM states: RUN (default), MEM_WAIT, ABORT. Reset (rst=0) forces RUN, wait counter 0, mem_err 0.
- While rst=0, outputs are forced to:
  - all stalls 0;
  - flushD=flushE=flushW=1;
  - forward selects 00.
- Forwarding is combinational and evaluated in every state.
  - forward_AE=10 if rf_enM && rdM!=0 && rdM==rs1E.
  - Otherwise 01 if rf_enW && rdW!=0 && rdW==rs1E.
  - Otherwise 00. M has priority over W. forward_BE is the same logic using rs2E.
- Load-use (RUN only): condition is mem_readE && rdE!=0 && (rdE==rs1D || rdE==rs2D).
  - Response: stallF=stallD=1 and flushE=1 in the same cycle. One bubble per hazard.
- Redirect (RUN only): jump_enE=1 gives flushD=flushE=1 with no stalls. Redirect overrides load-use in the same cycle: the load-use stall is suppressed.
- Memory wait: in RUN, dmem_req && !dmem_ready →
  - same cycle: stallF=stallD=stallE=stallM=1, flushW=1;
  - next state MEM_WAIT, wait counter loaded with 1.
  Redirect and load-use actions are suppressed that cycle. The held jump re-presents after the wait.
- MEM_WAIT: same stall/flushW outputs as above.
  - dmem_ready=1: that cycle releases all stalls (flushW=0) and the next state is RUN.
  - Else counter increments. When counter==MEM_TIMEOUT with no ready, next state is ABORT.
- ABORT (one cycle): mem_err=1, flushD=flushE=flushW=1, no stalls, next state RUN. This discards the faulting instruction and its followers.
- dmem_ready arriving in the same cycle as dmem_req in RUN: no stall, stay in RUN.
- Reset asserted mid-MEM_WAIT returns to RUN immediately (asynchronous reset); the counter clears.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments on every cycle with stallF=1.
  - flush_cnt increments on every cycle with flushE=1 while rst=1.
  - Both counters wrap at 2^CNT_W and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Load x5 in E (mem_readE=1, rdE=5), rs1D=5 → one cycle stallF=stallD=flushE=1, then RUN outputs return to all 0.
- rdM=rdW=7, rf_enM=rf_enW=1, rs1E=7 → forward_AE=10; rdM=0 with rdW=7 → forward_AE=01; rs2E=0 → forward_BE=00.
- jump_enE=1 together with a load-use condition → flushD=flushE=1, stallF=stallD=0.
- dmem_req=1, dmem_ready low for 3 cycles then high → stalls high for 3 cycles, low in the ready cycle, FSM back to RUN.
- dmem_ready never asserted, MEM_TIMEOUT=4 → stalls held 4 cycles, then one ABORT cycle with mem_err=1 and all flushes=1, then RUN.
- rst driven low during MEM_WAIT → stalls drop and flushes assert immediately without waiting for clk; stall_cnt=0 under HAZARD_PERF_EN.
